calc1_unit: RTL and testbench
=============================

// Module: calc1_unit
// PURPOSE
//   Four-port integer calculator. Each requester port issues a command with two
//   32-bit operands on consecutive cycles and receives a response code plus result.
//   Ports run independently. The block sits behind four request channels as a shared
//   arithmetic service.
// PARAMETERS
//   None. Widths are fixed: data 32 bits, command 4 bits, response 2 bits, 4 ports.
// PORTS (vectors are big-endian [0:N]; bit 0 = MSB)
//   c_clk         in   1     single clock, rising edge
//   reset         in   7     [1:7], asynchronous, active-high; any bit high resets the block
//   reqN_cmd_in   in   4     N=1..4; command in first cycle, 0 otherwise
//   reqN_data_in  in   32    N=1..4; operand1 with cmd, operand2 on the next cycle
//   out_dataN     out  32    N=1..4; result
//   out_respN     out  2     N=1..4; 0=none, 1=success, 2=error (overflow/underflow/invalid), 3=never
// BEHAVIOUR
//   Reset:
//   - While any reset bit is high, all out_dataN=0, out_respN=0, and every port FSM is IDLE.
//   - Reset mid-operation aborts the operation; no response is produced for it.
//   Per-port FSM, states IDLE -> OP2 -> RESP -> IDLE:
//   - IDLE, edge with cmd!=0: latch cmd and data as operand1; go to OP2.
//   - IDLE, edge with cmd==0: stay in IDLE.
//   - OP2: latch data as operand2 regardless of cmd; compute; go to RESP.
//   - RESP: drive out_respN for exactly one cycle; then return to IDLE.
//   - cmd!=0 while in OP2 or RESP is ignored. No queuing.
//   Latency:
//   - Command sampled at edge E1, operand2 sampled at edge E2.
//   - out_respN/out_dataN update at edge E3.
//   - out_respN returns to 0 at edge E4.
//   - out_dataN holds its last value until the next response on that port.
//   Commands:
//   - 1 ADD: op1+op2 unsigned. Carry out of bit 0 -> resp 2, data 0.
//   - 2 SUB: op1-op2 unsigned. op2>op1 (underflow) -> resp 2, data 0. op1==op2 -> resp 1, data 0.
//   - 5 SHL: op1 shifted left logically by op2[27:31] (0..31); zero fill; resp 1.
//   - 6 SHR: op1 shifted right logically by op2[27:31]; zero fill; resp 1.
//   - 3, 4, 7..15 invalid: still consume the operand2 cycle; resp 2, data 0.
//   Boundaries:
//   - FFFF_FFFF+1 overflows -> resp 2.
//   - FFFF_FFFF+0 succeeds -> resp 1, data FFFF_FFFF.
//   - 0+0 -> resp 1, data 0 (success, not "no response").
//   - Shifts never report error; shift by 0 returns op1.
//   - Simultaneous commands on all four ports complete in parallel with identical latency.
//   - One port's error never affects another port.
// TESTING
//   - Reset: hold reset[1]=1 for 4 cycles -> all out_resp=0, out_data=0. Repeat with only reset[7].
//   - Port1 ADD 0000_0001 + 1FFF_FFFF -> resp 1, data 2000_0000.
//     Port1 ADD 1FFF_FFFF + 1FFF_FFFF -> resp 1, data 3FFF_FFFE.
//     Port1 ADD 0 + 0 -> resp 1, data 0.
//   - Port1 ADD FFFF_FFFF + 1 -> resp 2.
//     Port1 SUB 1 - F -> resp 2.
//     Port1 cmd 3, then cmd 4 -> resp 2 each, at E3.
//   - Port1 ADD x + 0 for x = 1, 2, 4, 8, 16 -> resp 1, data x; out_data1 still equals x 3 cycles later.
//   - Ports 1-4 in the same cycle: ADD 5+3, SUB 9-4, SHL 1<<31, SHR 8000_0000>>31
//     -> resp 1 on all ports; data 8, 5, 8000_0000, 0000_0001.
//   - Reset asserted at E2 of a port1 ADD -> no response ever appears for it; the next command works normally.

Source files
------------

// File: rtl/calc1_unit.sv
// Four-port integer calculator: each port takes cmd+operand1, then operand2, and answers
// two edges later with a one-cycle response code and a held result.
// Vectors are declared [N-1:0]; legacy big-endian bit 0 is the MSB here, so op2[27:31] is op2[4:0].

module calc1_port (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  cmd_in,
  input  logic [31:0] data_in,
  output logic [31:0] out_data,
  output logic [1:0]  out_resp
);
  // state | meaning
  // IDLE  | waiting for a non-zero command; out_resp cleared
  // OP2   | operand1 and command held, sampling operand2
  // RESP  | result computed, publishing response on the next edge
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OP2  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RESP_OK  = 2'd1;
  localparam logic [1:0] RESP_ERR = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cmd_q;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [32:0] sum;
  logic [31:0] res_data;
  logic [1:0]  res_resp;

  always_comb begin
    sum      = {1'b0, op1} + {1'b0, op2};
    res_data = '0;
    res_resp = RESP_ERR;
    case (cmd_q)
      CMD_ADD: begin
        if (!sum[32]) begin
          res_data = sum[31:0];
          res_resp = RESP_OK;
        end
      end
      CMD_SUB: begin
        if (op2 <= op1) begin
          res_data = op1 - op2;
          res_resp = RESP_OK;
        end
      end
      CMD_SHL: begin
        res_data = op1 << op2[4:0];
        res_resp = RESP_OK;
      end
      CMD_SHR: begin
        res_data = op1 >> op2[4:0];
        res_resp = RESP_OK;
      end
      default: begin
        res_data = '0;
        res_resp = RESP_ERR;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cmd_q    <= '0;
      op1      <= '0;
      op2      <= '0;
      out_data <= '0;
      out_resp <= '0;
    end else begin
      case (state)
        IDLE: begin
          out_resp <= '0;
          if (cmd_in != 4'd0) begin
            cmd_q <= cmd_in;
            op1   <= data_in;
            state <= OP2;
          end
        end
        OP2: begin
          op2   <= data_in;
          state <= RESP;
        end
        RESP: begin
          out_resp <= res_resp;
          out_data <= res_data;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

module calc1_unit (
  input  logic        c_clk,
  input  logic [6:0]  reset,
  input  logic [3:0]  req1_cmd_in,
  input  logic [31:0] req1_data_in,
  input  logic [3:0]  req2_cmd_in,
  input  logic [31:0] req2_data_in,
  input  logic [3:0]  req3_cmd_in,
  input  logic [31:0] req3_data_in,
  input  logic [3:0]  req4_cmd_in,
  input  logic [31:0] req4_data_in,
  output logic [31:0] out_data1,
  output logic [1:0]  out_resp1,
  output logic [31:0] out_data2,
  output logic [1:0]  out_resp2,
  output logic [31:0] out_data3,
  output logic [1:0]  out_resp3,
  output logic [31:0] out_data4,
  output logic [1:0]  out_resp4
);
  // Any of the seven reset lines clears every port asynchronously.
  logic rst;
  assign rst = |reset;

  calc1_port u_port1 (.clk(c_clk), .rst(rst), .cmd_in(req1_cmd_in), .data_in(req1_data_in),
                      .out_data(out_data1), .out_resp(out_resp1));
  calc1_port u_port2 (.clk(c_clk), .rst(rst), .cmd_in(req2_cmd_in), .data_in(req2_data_in),
                      .out_data(out_data2), .out_resp(out_resp2));
  calc1_port u_port3 (.clk(c_clk), .rst(rst), .cmd_in(req3_cmd_in), .data_in(req3_data_in),
                      .out_data(out_data3), .out_resp(out_resp3));
  calc1_port u_port4 (.clk(c_clk), .rst(rst), .cmd_in(req4_cmd_in), .data_in(req4_data_in),
                      .out_data(out_data4), .out_resp(out_resp4));
endmodule

// File: tb/tb_calc1_unit.sv
// Directed bench for calc1_unit: a table of single-port operations on port 1 plus
// hand-written sequences for reset, hold, parallel ports and reset mid-operation.
module tb_calc1_unit;
  logic        c_clk = 1'b0;
  logic [6:0]  reset;
  logic [3:0]  cmd  [1:4];
  logic [31:0] din  [1:4];
  logic [31:0] odat [1:4];
  logic [1:0]  oresp[1:4];

  int passed = 0;
  int total  = 0;

  always #5 c_clk = ~c_clk;

  calc1_unit dut (
    .c_clk(c_clk), .reset(reset),
    .req1_cmd_in(cmd[1]), .req1_data_in(din[1]),
    .req2_cmd_in(cmd[2]), .req2_data_in(din[2]),
    .req3_cmd_in(cmd[3]), .req3_data_in(din[3]),
    .req4_cmd_in(cmd[4]), .req4_data_in(din[4]),
    .out_data1(odat[1]), .out_resp1(oresp[1]),
    .out_data2(odat[2]), .out_resp2(oresp[2]),
    .out_data3(odat[3]), .out_resp3(oresp[3]),
    .out_data4(odat[4]), .out_resp4(oresp[4])
  );

  typedef struct {
    string       name;
    logic [3:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  resp;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle_all();
    for (int p = 1; p <= 4; p++) begin
      cmd[p] = 4'd0;
      din[p] = 32'd0;
    end
  endtask

  // Drive at negedge; E1/E2 are the following posedges, checks land at negedge after E3 and E4.
  task automatic run_op(input string name, input int p, input logic [3:0] c,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] er, input logic [31:0] ed);
    @(negedge c_clk);
    cmd[p] = c; din[p] = a;
    @(negedge c_clk);
    cmd[p] = 4'd0; din[p] = b;
    @(negedge c_clk);
    din[p] = 32'd0;
    chk({name, " resp_before_e3"}, {30'd0, oresp[p]}, 32'd0);
    @(negedge c_clk);
    chk({name, " resp"}, {30'd0, oresp[p]}, {30'd0, er});
    chk({name, " data"}, odat[p], ed);
    @(negedge c_clk);
    chk({name, " resp_cleared"}, {30'd0, oresp[p]}, 32'd0);
    chk({name, " data_held"}, odat[p], ed);
  endtask

  task automatic check_all_zero(input string name);
    for (int p = 1; p <= 4; p++) begin
      chk($sformatf("%s resp%0d", name, p), {30'd0, oresp[p]}, 32'd0);
      chk($sformatf("%s data%0d", name, p), odat[p], 32'd0);
    end
  endtask

  initial begin
    idle_all();
    reset = 7'b1000000;
    vecs.push_back('{"add_1_1fff",     4'd1, 32'h0000_0001, 32'h1FFF_FFFF, 2'd1, 32'h2000_0000});
    vecs.push_back('{"add_1fff_1fff",  4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF, 2'd1, 32'h3FFF_FFFE});
    vecs.push_back('{"add_0_0",        4'd1, 32'h0,         32'h0,         2'd1, 32'h0});
    vecs.push_back('{"add_ovf",        4'd1, 32'hFFFF_FFFF, 32'h1,         2'd2, 32'h0});
    vecs.push_back('{"add_max_0",      4'd1, 32'hFFFF_FFFF, 32'h0,         2'd1, 32'hFFFF_FFFF});
    vecs.push_back('{"sub_underflow",  4'd2, 32'h1,         32'hF,         2'd2, 32'h0});
    vecs.push_back('{"sub_equal",      4'd2, 32'h7,         32'h7,         2'd1, 32'h0});
    vecs.push_back('{"sub_10_3",       4'd2, 32'h10,        32'h3,         2'd1, 32'hD});
    vecs.push_back('{"inv_cmd3",       4'd3, 32'h5,         32'h6,         2'd2, 32'h0});
    vecs.push_back('{"inv_cmd4",       4'd4, 32'h5,         32'h6,         2'd2, 32'h0});
    vecs.push_back('{"inv_cmd15",      4'd15, 32'h5,        32'h6,         2'd2, 32'h0});
    vecs.push_back('{"shl_by0",        4'd5, 32'h0000_00F0, 32'h0,         2'd1, 32'h0000_00F0});
    vecs.push_back('{"shl_3_by4",      4'd5, 32'h3,         32'h4,         2'd1, 32'h30});
    vecs.push_back('{"shl_amt_mask",   4'd5, 32'h1,         32'h25,        2'd1, 32'h20});
    vecs.push_back('{"shr_msb_by4",    4'd6, 32'h8000_0000, 32'h4,         2'd1, 32'h0800_0000});
    vecs.push_back('{"shr_by0",        4'd6, 32'hA5A5_0001, 32'h0,         2'd1, 32'hA5A5_0001});

    // Reset on the MSB line only.
    repeat (4) @(negedge c_clk);
    check_all_zero("rst_msb");
    reset = 7'b0;

    // Make port1 data non-zero, then reset on the LSB line only.
    run_op("pre_rst", 1, 4'd1, 32'h11, 32'h22, 2'd1, 32'h33);
    reset = 7'b0000001;
    repeat (4) @(negedge c_clk);
    check_all_zero("rst_lsb");
    reset = 7'b0;

    foreach (vecs[i])
      run_op(vecs[i].name, 1, vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].resp, vecs[i].data);

    // x+0 results must persist while the port is idle.
    for (int k = 0; k < 5; k++) begin
      logic [31:0] x;
      x = 32'd1 << k;
      run_op($sformatf("add_x%0d_0", x), 1, 4'd1, x, 32'd0, 2'd1, x);
      repeat (3) @(negedge c_clk);
      chk($sformatf("hold_x%0d", x), odat[1], x);
    end

    // All four ports in the same cycle.
    @(negedge c_clk);
    cmd[1] = 4'd1; din[1] = 32'd5;
    cmd[2] = 4'd2; din[2] = 32'd9;
    cmd[3] = 4'd5; din[3] = 32'd1;
    cmd[4] = 4'd6; din[4] = 32'h8000_0000;
    @(negedge c_clk);
    for (int p = 1; p <= 4; p++) cmd[p] = 4'd0;
    din[1] = 32'd3; din[2] = 32'd4; din[3] = 32'd31; din[4] = 32'd31;
    @(negedge c_clk);
    idle_all();
    @(negedge c_clk);
    for (int p = 1; p <= 4; p++) chk($sformatf("par resp%0d", p), {30'd0, oresp[p]}, 32'd1);
    chk("par data1", odat[1], 32'd8);
    chk("par data2", odat[2], 32'd5);
    chk("par data3", odat[3], 32'h8000_0000);
    chk("par data4", odat[4], 32'h0000_0001);

    // Error on port 2 alongside success on port 1.
    @(negedge c_clk);
    cmd[1] = 4'd1; din[1] = 32'd2;
    cmd[2] = 4'd1; din[2] = 32'hFFFF_FFFF;
    @(negedge c_clk);
    cmd[1] = 4'd0; cmd[2] = 4'd0; din[1] = 32'd2; din[2] = 32'd2;
    @(negedge c_clk);
    idle_all();
    @(negedge c_clk);
    chk("iso resp1", {30'd0, oresp[1]}, 32'd1);
    chk("iso data1", odat[1], 32'd4);
    chk("iso resp2", {30'd0, oresp[2]}, 32'd2);
    chk("iso data2", odat[2], 32'd0);

    // Command asserted while a port is busy is ignored.
    @(negedge c_clk);
    cmd[1] = 4'd1; din[1] = 32'd10;
    @(negedge c_clk);
    cmd[1] = 4'd2; din[1] = 32'd20;
    @(negedge c_clk);
    cmd[1] = 4'd0; din[1] = 32'd0;
    @(negedge c_clk);
    chk("busy resp", {30'd0, oresp[1]}, 32'd1);
    chk("busy data", odat[1], 32'd30);
    @(negedge c_clk);
    chk("busy no_second_resp", {30'd0, oresp[1]}, 32'd0);
    @(negedge c_clk);
    chk("busy still_idle", {30'd0, oresp[1]}, 32'd0);

    // Reset across E2 of an ADD aborts it.
    @(negedge c_clk);
    cmd[1] = 4'd1; din[1] = 32'd7;
    @(negedge c_clk);
    cmd[1] = 4'd0; din[1] = 32'd8;
    reset = 7'b0001000;
    @(negedge c_clk);
    reset = 7'b0;
    din[1] = 32'd0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("abort resp c%0d", c), {30'd0, oresp[1]}, 32'd0);
      chk($sformatf("abort data c%0d", c), odat[1], 32'd0);
      @(negedge c_clk);
    end
    run_op("after_abort", 1, 4'd1, 32'd7, 32'd8, 2'd1, 32'd15);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
